// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter: serialises MIPS fetch and load/store traffic onto one
// shared req/addr_ok/data_ok memory port. Data has priority, and a starvation guard protects fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  typedef enum logic {OWN_INST, OWN_DATA} owner_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  starve_q, starve_d;
  logic        grant_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= OWN_INST;
      wr_q     <= 1'b0;
      wstrb_q  <= 4'b0;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      starve_q <= 3'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      wstrb_q  <= wstrb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Fetch overrides data only once STARVE_MAX data grants have passed it by.
  assign grant_data = data_req_i && !(inst_req_i && (starve_q == STARVE_LIM));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wr_d           = wr_q;
    wstrb_d        = wstrb_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    starve_d       = starve_q;
    inst_addr_ok_o = 1'b0;
    data_addr_ok_o = 1'b0;
    inst_data_ok_o = 1'b0;
    data_data_ok_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          data_addr_ok_o = 1'b1;
          state_d        = ADDR;
          owner_d        = OWN_DATA;
          wr_d           = data_wr_i;
          wstrb_d        = data_wstrb_i;
          addr_d         = data_addr_i;
          wdata_d        = data_wdata_i;
          if (!inst_req_i)
            starve_d = 3'b0;
          else if (starve_q != STARVE_LIM)
            starve_d = 3'(starve_q + 3'd1);
        end else if (inst_req_i) begin
          inst_addr_ok_o = 1'b1;
          state_d        = ADDR;
          owner_d        = OWN_INST;
          wr_d           = 1'b0;
          wstrb_d        = 4'b0;
          addr_d         = inst_addr_i;
          wdata_d        = 32'b0;
          starve_d       = 3'b0;
        end
      end
      ADDR: begin
        if (mem_addr_ok_i)
          state_d = DATA;
      end
      DATA: begin
        if (mem_data_ok_i) begin
          state_d = IDLE;
          if (owner_q == OWN_DATA)
            data_data_ok_o = 1'b1;
          else
            inst_data_ok_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs must read 0 for the whole reset, even with requests held.
    if (!rst_ni) begin
      inst_addr_ok_o = 1'b0;
      data_addr_ok_o = 1'b0;
      inst_data_ok_o = 1'b0;
      data_data_ok_o = 1'b0;
    end
  end

  assign mem_req_o    = (state_q == ADDR);
  assign mem_wr_o     = wr_q;
  assign mem_wstrb_o  = wstrb_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign inst_rdata_o = rst_ni ? mem_rdata_i : 32'b0;
  assign data_rdata_o = rst_ni ? mem_rdata_i : 32'b0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for arbitration, starvation, reset and stray handshakes.
module tb_mem_port_arbiter;

  typedef struct {
    logic        isData;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          addrDelay;
    int          dataDelay;
    logic        stray;
    logic        expWr;
    logic [3:0]  expWstrb;
    logic [31:0] expWdata;
    logic        checkRd;
  } txnVec_t;

  logic        clk;
  logic        rstN;
  logic        instReq;
  logic [31:0] instAddr;
  logic        instAddrOk;
  logic        instDataOk;
  logic [31:0] instRdata;
  logic        dataReq;
  logic        dataWr;
  logic [3:0]  dataWstrb;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        dataAddrOk;
  logic        dataDataOk;
  logic [31:0] dataRdata;
  logic        memReq;
  logic        memWr;
  logic [3:0]  memWstrb;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memAddrOk;
  logic        memDataOk;
  logic [31:0] memRdata;

  int total = 0;
  int bad   = 0;

  txnVec_t vecs[4];

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .inst_req_i     (instReq),
    .inst_addr_i    (instAddr),
    .inst_addr_ok_o (instAddrOk),
    .inst_data_ok_o (instDataOk),
    .inst_rdata_o   (instRdata),
    .data_req_i     (dataReq),
    .data_wr_i      (dataWr),
    .data_wstrb_i   (dataWstrb),
    .data_addr_i    (dataAddr),
    .data_wdata_i   (dataWdata),
    .data_addr_ok_o (dataAddrOk),
    .data_data_ok_o (dataDataOk),
    .data_rdata_o   (dataRdata),
    .mem_req_o      (memReq),
    .mem_wr_o       (memWr),
    .mem_wstrb_o    (memWstrb),
    .mem_addr_o     (memAddr),
    .mem_wdata_o    (memWdata),
    .mem_addr_ok_i  (memAddrOk),
    .mem_data_ok_i  (memDataOk),
    .mem_rdata_i    (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'b0, actual}, {31'b0, expected});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctl"},
                {22'b0, memReq, memWr, instAddrOk, instDataOk, dataAddrOk, dataDataOk, memWstrb}, 32'b0);
    checkOutput({tag, " mem_addr"},   memAddr,   32'b0);
    checkOutput({tag, " mem_wdata"},  memWdata,  32'b0);
    checkOutput({tag, " inst_rdata"}, instRdata, 32'b0);
    checkOutput({tag, " data_rdata"}, dataRdata, 32'b0);
  endtask

  // Called at the negedge just after the grant edge (DUT in ADDR); returns at
  // negedge+1 of the first IDLE cycle after completion.
  task automatic completeTxn(input logic isData, input logic expWr, input logic [3:0] expWstrb,
                             input logic [31:0] expAddr, input logic [31:0] expWdata,
                             input logic [31:0] rdata, input logic checkRd,
                             input int addrDelay, input int dataDelay, input logic stray);
    int reqCycles = 0;
    for (int k = 0; k <= addrDelay; k++) begin
      if (k == addrDelay) memAddrOk = 1'b1;
      #1;
      if (memReq) reqCycles++;
      checkOutput("addr phase addr_ok", {30'b0, instAddrOk, dataAddrOk}, 32'b0);
      if (k == 0) begin
        checkBit("mem_wr", memWr, expWr);
        checkOutput("mem_wstrb", {28'b0, memWstrb}, {28'b0, expWstrb});
        checkOutput("mem_addr", memAddr, expAddr);
        checkOutput("mem_wdata", memWdata, expWdata);
      end
      @(negedge clk);
      memAddrOk = 1'b0;
    end
    checkOutput("mem_req cycles", reqCycles, addrDelay + 1);
    for (int k = 1; k <= dataDelay; k++) begin
      if (stray) memAddrOk = (k < dataDelay);
      if (k == dataDelay) begin
        memDataOk = 1'b1;
        memRdata  = rdata;
      end
      #1;
      checkBit("data phase mem_req", memReq, 1'b0);
      if (k < dataDelay) begin
        checkOutput("early data_ok", {30'b0, instDataOk, dataDataOk}, 32'b0);
      end else begin
        checkBit("owner data_ok", isData ? dataDataOk : instDataOk, 1'b1);
        checkBit("other data_ok", isData ? instDataOk : dataDataOk, 1'b0);
        if (checkRd) checkOutput("rdata", isData ? dataRdata : instRdata, rdata);
      end
      @(negedge clk);
      memDataOk = 1'b0;
      memAddrOk = 1'b0;
      memRdata  = 32'hFFFF0000;
    end
    #1;
    checkOutput("after data_ok", {29'b0, memReq, instDataOk, dataDataOk}, 32'b0);
  endtask

  task automatic applyStimulus(input txnVec_t v);
    @(negedge clk);
    if (v.isData) begin
      dataReq   = 1'b1;
      dataWr    = v.wr;
      dataWstrb = v.wstrb;
      dataAddr  = v.addr;
      dataWdata = v.wdata;
    end else begin
      instReq   = 1'b1;
      instAddr  = v.addr;
      dataWr    = v.wr;
      dataWstrb = v.wstrb;
      dataWdata = v.wdata;
      dataAddr  = 32'h0BAD0BAD;
    end
    #1;
    checkBit("grant inst_addr_ok", instAddrOk, !v.isData);
    checkBit("grant data_addr_ok", dataAddrOk, v.isData);
    checkBit("grant mem_req", memReq, 1'b0);
    @(negedge clk);
    instReq = 1'b0;
    dataReq = 1'b0;
    completeTxn(v.isData, v.expWr, v.expWstrb, v.addr, v.expWdata, v.rdata, v.checkRd,
                v.addrDelay, v.dataDelay, v.stray);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h0, 32'h24080001, 1, 3, 1'b0,
                1'b0, 4'h0, 32'h0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h80001004, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0,
                1'b1, 4'b0011, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h80002000, 32'h0, 32'h12345678, 2, 2, 1'b1,
                1'b0, 4'h0, 32'h0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 4'hF, 32'hBFC00004, 32'hCAFEF00D, 32'h3C1D8000, 0, 1, 1'b0,
                1'b0, 4'h0, 32'h0, 1'b1};

    rstN = 1'b0; instReq = 1'b0; instAddr = 32'h0;
    dataReq = 1'b0; dataWr = 1'b0; dataWstrb = 4'h0; dataAddr = 32'h0; dataWdata = 32'h0;
    memAddrOk = 1'b0; memDataOk = 1'b0; memRdata = 32'h5555AAAA;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    memRdata = 32'hFFFF0000;

    $display("[TB] table transactions");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    $display("[TB] request dropped before accept");
    @(negedge clk);
    dataReq = 1'b1; dataWr = 1'b0; dataAddr = 32'h80005000;
    #1;
    checkBit("drop comb addr_ok", dataAddrOk, 1'b1);
    #1;
    dataReq = 1'b0;
    @(negedge clk);
    #1;
    checkBit("drop mem_req", memReq, 1'b0);

    $display("[TB] stray handshakes in IDLE");
    @(negedge clk);
    memDataOk = 1'b1; memAddrOk = 1'b1; memRdata = 32'h77777777;
    #1;
    checkOutput("stray idle data_ok", {30'b0, instDataOk, dataDataOk}, 32'b0);
    @(negedge clk);
    memDataOk = 1'b0; memAddrOk = 1'b0;
    #1;
    checkBit("stray idle mem_req", memReq, 1'b0);

    $display("[TB] simultaneous requests");
    @(negedge clk);
    instReq = 1'b1; instAddr = 32'hBFC00200;
    dataReq = 1'b1; dataWr = 1'b1; dataWstrb = 4'hF; dataAddr = 32'h80004000; dataWdata = 32'hA5A5A5A5;
    #1;
    checkBit("simul data_addr_ok", dataAddrOk, 1'b1);
    checkBit("simul inst_addr_ok", instAddrOk, 1'b0);
    @(negedge clk);
    dataReq = 1'b0;
    completeTxn(1'b1, 1'b1, 4'hF, 32'h80004000, 32'hA5A5A5A5, 32'h0, 1'b0, 0, 1, 1'b0);
    checkBit("simul inst_addr_ok after", instAddrOk, 1'b1);
    @(negedge clk);
    instReq = 1'b0;
    completeTxn(1'b0, 1'b0, 4'h0, 32'hBFC00200, 32'h0, 32'h8FBF0010, 1'b1, 0, 1, 1'b0);

    $display("[TB] starvation guard");
    @(negedge clk);
    instReq = 1'b1; instAddr = 32'hBFC00100;
    dataReq = 1'b1; dataWr = 1'b0; dataWstrb = 4'h0; dataAddr = 32'h80003000; dataWdata = 32'h11111111;
    #1;
    for (int g = 1; g <= 4; g++) begin
      checkBit("starve data grant", dataAddrOk, 1'b1);
      checkBit("starve inst held", instAddrOk, 1'b0);
      @(negedge clk);
      completeTxn(1'b1, 1'b0, 4'h0, 32'h80003000, 32'h11111111, 32'h00000100 + g, 1'b1, 0, 1, 1'b0);
    end
    checkBit("starve inst wins", instAddrOk, 1'b1);
    checkBit("starve data loses", dataAddrOk, 1'b0);
    @(negedge clk);
    instReq = 1'b0;
    completeTxn(1'b0, 1'b0, 4'h0, 32'hBFC00100, 32'h0, 32'h03E00008, 1'b1, 1, 1, 1'b0);
    instReq = 1'b1;
    #1;
    checkBit("post-starve data wins", dataAddrOk, 1'b1);
    checkBit("post-starve inst loses", instAddrOk, 1'b0);
    @(negedge clk);
    dataReq = 1'b0;
    completeTxn(1'b1, 1'b0, 4'h0, 32'h80003000, 32'h11111111, 32'h0000BEEF, 1'b1, 0, 1, 1'b0);
    checkBit("post-starve inst grant", instAddrOk, 1'b1);
    @(negedge clk);
    instReq = 1'b0;
    completeTxn(1'b0, 1'b0, 4'h0, 32'hBFC00100, 32'h0, 32'h03E00008, 1'b1, 0, 1, 1'b0);

    $display("[TB] reset mid-transaction");
    @(negedge clk);
    instReq = 1'b1; instAddr = 32'hBFC00300;
    #1;
    checkBit("pre-reset grant", instAddrOk, 1'b1);
    @(negedge clk);
    instReq = 1'b0; memAddrOk = 1'b1;
    @(negedge clk);
    memAddrOk = 1'b0;
    #1;
    rstN = 1'b0; memRdata = 32'hFFFFFFFF;
    #1;
    checkAllZero("async reset");
    memDataOk = 1'b1; instReq = 1'b1;
    @(negedge clk);
    #1;
    checkAllZero("held reset");
    rstN = 1'b1; memDataOk = 1'b0; memRdata = 32'hFFFF0000;
    #1;
    checkBit("post-reset inst grant", instAddrOk, 1'b1);
    checkOutput("post-reset data_ok", {30'b0, instDataOk, dataDataOk}, 32'b0);
    @(negedge clk);
    instReq = 1'b0;
    completeTxn(1'b0, 1'b0, 4'h0, 32'hBFC00300, 32'h0, 32'h2402000A, 1'b1, 0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the mips core, between its instruction-fetch and data SRAM-like ports and a single shared memory port.
- The shared memory port uses req/addr_ok/data_ok handshakes with variable latency.
- Serialises the instruction and data requests with one transaction outstanding at a time.
- Data has priority, with a starvation guard for instruction fetch.
- Gives the core explicit accept (addr_ok) and completion (data_ok) pulses, which drive its stall logic.

Parameters:
STARVE_MAX, 4, number of consecutive data grants made while inst_req is pending, after which instruction fetch wins the next arbitration (1..7).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  32  fetch data
data_req  in  1  load/store request, held until data_addr_ok
data_wr  in  1  1 = store, 0 = load
data_wstrb  in  4  byte enables for a store
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  load/store accepted this cycle
data_data_ok  out  1  load data valid / store complete this cycle
data_rdata  out  32  load data
mem_req  out  1  request to memory
mem_wr  out  1  write flag
mem_wstrb  out  4  byte enables
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_addr_ok  in  1  memory accepted the request
mem_data_ok  in  1  memory response valid
mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset: clk, single clock; rst asynchronous, active-low.
- While rst=0:
  - state=IDLE, owner=INST, starve_cnt=0.
  - All latched fields are 0.
  - All outputs are 0.
- Reset mid-transaction abandons the transaction; no data_ok is ever issued for it. The memory side is reset by the same rst.
- FSM states: IDLE, ADDR, DATA.
- IDLE, arbitration (only when at least one request is present):
  - Data wins if data_req=1, except when inst_req=1 and starve_cnt==STARVE_MAX; in that case inst wins.
  - Winner's *_addr_ok=1 combinationally this cycle. Loser's addr_ok=0.
  - On the clock edge, latch owner, wr, wstrb, addr and wdata, then go to ADDR.
  - Instruction grants latch wr=0, wstrb=0, wdata=0.
- starve_cnt, updated at each grant:
  - Data grant with inst_req=1: increment, saturating at STARVE_MAX.
  - Any instruction grant, or a data grant with inst_req=0: clear to 0.
- ADDR:
  - mem_req=1; mem_wr, mem_wstrb, mem_addr, mem_wdata driven from latched registers.
  - Stay in ADDR until mem_addr_ok=1, then go to DATA.
  - Both *_addr_ok outputs are 0 in this state.
- DATA:
  - mem_req=0.
  - When mem_data_ok=1, the owner's *_data_ok=1 combinationally and *_rdata=mem_rdata; go to IDLE next cycle.
  - The non-owner's data_ok stays 0. Stores also receive data_ok; data_rdata is don't-care for stores.
- Outside ADDR, mem_req=0, and mem_wr, mem_wstrb, mem_addr, mem_wdata hold their latched values.
- The *_rdata outputs equal mem_rdata at all times, so they are only meaningful while the matching data_ok is high.
- Latency: minimum request-to-data_ok is 3 cycles (accept in IDLE, 1 cycle in ADDR, data_ok in DATA). There is one idle bubble between back-to-back transactions.
- Boundary conditions:
  - mem_data_ok while not in DATA is ignored.
  - mem_addr_ok while not in ADDR is ignored.
  - A request deasserted before accept is dropped silently.
  - Address and strobes are not checked; alignment exceptions are handled upstream in the core.
- No combinational path from mem_addr_ok to any mem_* output.

Test Plan:
- Single fetch:
  - Stimulus: inst_req=1, inst_addr=0xBFC00000; memory gives addr_ok after 2 cycles and data_ok=0x24080001 after 3 more cycles.
  - Required: inst_addr_ok pulses once; mem_req high for exactly 2 cycles with mem_addr=0xBFC00000 and mem_wr=0; inst_data_ok pulses once with inst_rdata=0x24080001; data_data_ok stays 0.
- Store:
  - Stimulus: data_req=1, data_wr=1, data_wstrb=4'b0011, data_addr=0x80001004, data_wdata=0xDEADBEEF.
  - Required: mem_wr=1, mem_wstrb=4'b0011, mem_wdata=0xDEADBEEF while mem_req; data_data_ok pulses once.
- Simultaneous requests:
  - Stimulus: inst_req and data_req both asserted in IDLE.
  - Required: data_addr_ok=1 and inst_addr_ok=0; after completion the instruction request is accepted; responses return in grant order.
- Starvation guard, STARVE_MAX=4:
  - Stimulus: inst_req held high while data_req is asserted continuously.
  - Required: exactly 4 data grants, then an instruction grant, then starve_cnt=0 and data wins again.
- Reset mid-transaction:
  - Stimulus: rst driven low while in DATA, then mem_data_ok=1 during reset.
  - Required: all outputs 0 immediately (asynchronous); no data_ok pulse; after release, a new inst_req is accepted within the first cycle in IDLE.
- Stray handshakes:
  - Stimulus: mem_data_ok=1 in IDLE and mem_addr_ok=1 in DATA.
  - Required: no data_ok pulse; state unchanged.
